// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher: one round per clock through a single shared round datapath.
// Byte n of a block sits at bits [8n+7:8n]; round key r is {rkey[4r+3], ..., rkey[4r]}.
module aes_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*(Nr+1)-1:0][31:0] rkey,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              pt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              ct,
  output logic                      busy
);

  localparam int CW = $clog2(Nr + 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    st_q, st_d;

  logic [127:0]    rk [Nr+1];
  logic [127:0]    sb, sr, mc, rnd;
  logic            last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  genvar gi;

  generate
    for (gi = 0; gi <= Nr; gi++) begin : g_rk
      assign rk[gi] = rkey[4*gi +: 4];
    end

    // Byte (row r, col c) lives at index 4c+r; row r rotates left by r columns.
    for (gi = 0; gi < 16; gi++) begin : g_sub_shift
      assign sb[8*gi +: 8] = SBOX[st_q[8*gi +: 8]];
      assign sr[8*gi +: 8] = sb[8*((gi % 4) + 4*(((gi / 4) + (gi % 4)) % 4)) +: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[32*gi +  0 +: 8];
      assign a1 = sr[32*gi +  8 +: 8];
      assign a2 = sr[32*gi + 16 +: 8];
      assign a3 = sr[32*gi + 24 +: 8];
      assign mc[32*gi +  0 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[32*gi +  8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[32*gi + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[32*gi + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  // The final round skips MixColumns.
  assign last_round = (cnt_q == CW'(Nr));
  assign rnd        = (last_round ? sr : mc) ^ rk[cnt_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = pt ^ rk[0];
          cnt_d   = CW'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d = rnd;
        if (last_round) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            st_d    = pt ^ rk[0];
            cnt_d   = CW'(1);
            state_d = ROUND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign ct        = st_q;
  assign busy      = (state_q != IDLE);

endmodule
